data_ready_pipe: RTL
====================

// Module: data_ready_pipe
// PURPOSE
//  Backward-registered valid/ready stage with a 2-entry skid buffer.
//  Breaks the combinational from_down_ready -> to_up_ready path at interfaces where the
//  consumer's ready is late, e.g. the VDMA read-data return into the stream output.
//  Sits between a producer and a consumer on the same valid/ready stream used throughout
//  the data_interface directory.
//  to_up_ready, to_down_vld and to_down_data are all driven from flops.
//  Full throughput of one beat per enabled cycle; strict in-order delivery.
// PARAMETERS
//  DSIZE  8  data width in bits
// PORTS
//  clock           in   1      sole clock; all logic on posedge
//  rst             in   1      synchronous reset, active-high
//  clk_en          in   1      cycle qualifier; when low no handshake completes and no state changes
//  from_up_vld     in   1      upstream beat valid
//  from_up_data    in   DSIZE  upstream beat data
//  to_up_ready     out  1      registered ready to upstream
//  from_down_ready in   1      downstream ready
//  to_down_vld     out  1      registered valid to downstream
//  to_down_data    out  DSIZE  registered data to downstream
//  occupancy       out  2      beats held: 0, 1 or 2
//  proto_err       out  1      sticky: upstream broke the hold rule
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=EMPTY, main_reg=skid_reg=0, to_up_ready=0 for the reset cycle,
//   to_down_vld=0, occupancy=0, proto_err=0.
//   First cycle after reset: to_up_ready=1.
//   A reset mid-transfer discards held beats without delivering them.
//  Handshake terms: push = from_up_vld & to_up_ready & clk_en; pop = to_down_vld & from_down_ready & clk_en.
//  States: EMPTY (0 beats), HALF (main valid), FULL (main+skid valid).
//   EMPTY: push -> HALF, main<=from_up_data; else stay.
//   HALF : push&!pop -> FULL, skid<=from_up_data.
//          push&pop -> HALF, main<=from_up_data.
//          !push&pop -> EMPTY; else stay.
//   FULL : pop -> HALF, main<=skid, skid<=0; else stay. push cannot occur (ready low).
//   Illegal encoding -> EMPTY.
//  Output decode (registered):
//   to_up_ready = (state != FULL)
//   to_down_vld = (state != EMPTY)
//   to_down_data = main_reg
//   occupancy = 0/1/2 by state
//  Latency: beat accepted at edge N is presented on to_down_vld/data after edge N (1 cycle).
//  Ready latency: downstream stall costs upstream exactly one extra accepted beat (skid),
//   then to_up_ready drops the cycle after FULL is entered.
//  clk_en low: state, data and outputs hold; pop/push are not counted even if vld&ready.
//  Data is not cleared on pop from HALF->EMPTY (to_down_data holds last value; vld=0).
//  proto_err: set when, on an enabled cycle, prev (from_up_vld & !to_up_ready) was true and
//   now from_up_vld=0 or from_up_data changed; remains 1 until rst.
//   Needs one DSIZE shadow register plus a 1-bit pending flag.
// STRUCTURE
//  Shared package data_if_pkg: typedef enum logic[1:0] {EMPTY=0,HALF=1,FULL=2} pipe_state_e.
//   Also holds the 2-bit occupancy constants.
//  Single module; the proto_err checker is kept as an always block.
//   No sub-module: no natural split at this size.
// TESTING
//  1 Stream 16 beats 0x01..0x10, from_down_ready=1, clk_en=1
//    -> out 0x01..0x10 in order, one per cycle, 1-cycle latency, occupancy stays 1.
//  2 Stream, then drop from_down_ready for 3 cycles mid-burst
//    -> exactly one extra beat accepted, to_up_ready=0 next cycle, occupancy=2;
//    after ready returns, no loss or duplicate.
//  3 Toggle clk_en 1-0-1 with vld=ready=1 throughout
//    -> beats move only on clk_en=1 cycles; outputs frozen otherwise.
//  4 Fill to FULL (0xAA, 0xBB), assert rst for 1 cycle
//    -> to_down_vld=0, occupancy=0, to_up_ready=0 during reset, 1 the following cycle;
//    0xAA/0xBB never appear afterwards.
//  5 Hold vld=1 with data 0x5A while FULL, change data to 0x5B before acceptance
//    -> proto_err=1 next cycle and stays 1 until rst.
//  6 Random vld/ready/clk_en for 10k cycles vs scoreboard
//    -> output sequence equals accepted sequence, proto_err=0 with a legal driver.

Source files
------------

// File: rtl/data_if_pkg.sv
// data_if_pkg: shared state encoding and occupancy constants for the valid/ready stream stages
package data_if_pkg;
   typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} pipe_state_e;
   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_HALF  = 2'd1;
   localparam logic [1:0] OCC_FULL  = 2'd2;
   function automatic logic [1:0] occ_of(input pipe_state_e s);
      return (s == FULL) ? OCC_FULL : (s == HALF) ? OCC_HALF : OCC_EMPTY;
   endfunction
endpackage

// File: rtl/data_ready_pipe.sv
// data_ready_pipe: backward-registered valid/ready stage with a 2-entry skid buffer
//   clock, rst, clk_en                  : clock, sync active-high reset, cycle qualifier
//   from_up_vld/from_up_data/to_up_ready : upstream side, ready is a flop
//   to_down_vld/to_down_data/from_down_ready : downstream side, valid/data are flops
//   occupancy                           : beats held (0..2)
//   proto_err                           : sticky flag, upstream dropped or changed a stalled beat
module data_ready_pipe
   import data_if_pkg::*;
#(
   parameter int DSIZE = 8
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             clk_en,
   input  logic             from_up_vld,
   input  logic [DSIZE-1:0] from_up_data,
   output logic             to_up_ready,
   input  logic             from_down_ready,
   output logic             to_down_vld,
   output logic [DSIZE-1:0] to_down_data,
   output logic [1:0]       occupancy,
   output logic             proto_err
);
   pipe_state_e      state_q, state_d;
   logic [DSIZE-1:0] main_q, main_d, skid_q, skid_d, shadow_q;
   logic             rdy_q, vld_q, pend_q, err_q, push, pop;
   logic [1:0]       occ_q;
   assign push = from_up_vld & rdy_q & clk_en;
   assign pop  = vld_q & from_down_ready & clk_en;
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: if (push) begin
            state_d = HALF;
            main_d  = from_up_data;
         end
         HALF: begin
            if (push && !pop) begin
               state_d = FULL;
               skid_d  = from_up_data;
            end else if (push && pop) main_d = from_up_data;
            else if (pop) state_d = EMPTY;
         end
         FULL: if (pop) begin
            state_d = HALF;
            main_d  = skid_q;
            skid_d  = '0;
         end
         default: state_d = EMPTY;
      endcase
   end
   // Outputs are registered from the next state so no output depends combinationally on from_down_ready
   always_ff @(posedge clock) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         rdy_q   <= 1'b0;
         vld_q   <= 1'b0;
         occ_q   <= OCC_EMPTY;
      end else if (clk_en) begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         rdy_q   <= state_d != FULL;
         vld_q   <= state_d != EMPTY;
         occ_q   <= occ_of(state_d);
      end
   end
   // A beat offered while ready was low must be re-offered unchanged on the next enabled cycle
   always_ff @(posedge clock) begin
      if (rst) begin
         pend_q   <= 1'b0;
         shadow_q <= '0;
         err_q    <= 1'b0;
      end else if (clk_en) begin
         pend_q   <= from_up_vld & ~rdy_q;
         shadow_q <= from_up_data;
         if (pend_q && (!from_up_vld || from_up_data != shadow_q)) err_q <= 1'b1;
      end
   end
   assign to_up_ready  = rdy_q;
   assign to_down_vld  = vld_q;
   assign to_down_data = main_q;
   assign occupancy    = occ_q;
   assign proto_err    = err_q;
endmodule
